// File: rtl/cipher_tx_pkg.sv
// Shared definitions for the cipher packet transmitter: FSM states, packet
// header constant, cipher block width and the payload-length rule.
package cipher_tx_pkg;

  localparam int         DATA_W   = 384;
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, HDR, LVL, WAIT_BLK, PAY, CHK, DONE
  } state_t;

  // Payload bytes taken from each cipher block for a given battery level.
  function automatic logic [5:0] bytes_per_level(input logic [2:0] level);
    case (level)
      3'd1:    return 6'd48;
      3'd2:    return 6'd32;
      default: return 6'd16;
    endcase
  endfunction

endpackage

// File: rtl/cipher_tx_sched_uart.sv
// uart_byte_tx: 8N1 byte transmitter.
//   Clk, Rst_n      clock, async active-low reset
//   tx_start        accepted while idle; tx_byte captured with it
//   tx_done         pulse in the last cycle of the stop bit
//   tx_busy         frame in progress
//   Rs232_Tx        serial line, idle high
module uart_byte_tx #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_done,
  output logic       tx_busy,
  output logic       Rs232_Tx
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    frame;    // {stop, data[7:0], start}, shifted out LSB first
  logic          bit_end;

  assign bit_end  = (baud_cnt == CW'(BAUD_DIV - 1));
  assign tx_done  = tx_busy && bit_end && (bit_cnt == 4'd9);
  // Gated by tx_busy so an async reset forces the line high at once.
  assign Rs232_Tx = !tx_busy || frame[0];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tx_busy  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      frame    <= '1;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy  <= 1'b1;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        frame    <= {1'b1, tx_byte, 1'b0};
      end
    end else if (bit_end) begin
      baud_cnt <= '0;
      if (bit_cnt == 4'd9) tx_busy <= 1'b0;
      else begin
        bit_cnt <= bit_cnt + 4'd1;
        frame   <= {1'b1, frame[9:1]};
      end
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cipher_tx_sched.sv
// cipher_tx_sched: frames cipher blocks into packets
//   HDR_BYTE, {5'b0,level}, N*B payload bytes (block LSB byte first), CHK
// and feeds them byte by byte to uart_byte_tx.
//   start/abort            packet request / level abandon request
//   all_group_num          block count N, latched on start
//   Battery_level          payload select, latched on start
//   blk_data/valid/ready   cipher block handshake
//   Rs232_Tx               serial output
//   busy/out_ok/aborted    packet status
module cipher_tx_sched
  import cipher_tx_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       all_group_num,
  input  logic [2:0]        Battery_level,
  input  logic [DATA_W-1:0] blk_data,
  input  logic              blk_valid,
  output logic              blk_ready,
  output logic              Rs232_Tx,
  output logic              busy,
  output logic              out_ok,
  output logic              aborted
);

  state_t              state, nxt;
  logic [2:0]          level_q;
  logic [31:0]         n_q, blk_cnt;
  logic [5:0]          byte_cnt, bpb;
  logic [DATA_W-1:0]   shreg;
  logic [7:0]          chk, tx_byte;
  logic                launched;   // current byte handed to the UART
  logic                tx_start, tx_done, tx_busy;
  logic                last_byte, last_blk, blk_take;

  assign bpb       = bytes_per_level(level_q);
  assign last_byte = (byte_cnt == bpb - 6'd1);
  assign last_blk  = (blk_cnt + 32'd1 == n_q);
  assign blk_take  = (state == WAIT_BLK) && blk_valid && !abort;

  assign blk_ready = (state == WAIT_BLK);
  assign busy      = (state != IDLE) && (state != DONE);
  assign out_ok    = (state == DONE);

  // The first byte of a block goes straight from blk_data in the handshake
  // cycle, so a block boundary costs no extra idle cycle on the line.
  assign tx_start = !launched && !tx_busy &&
                    ((state inside {HDR, LVL, PAY, CHK}) || blk_take);

  always_comb begin
    case (state)
      HDR:      tx_byte = HDR_BYTE;
      LVL:      tx_byte = {5'b0, level_q};
      WAIT_BLK: tx_byte = blk_data[7:0];
      PAY:      tx_byte = shreg[7:0];
      default:  tx_byte = chk;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (start) nxt = HDR;
      HDR:      if (tx_done) nxt = abort ? IDLE : LVL;
      LVL:      if (tx_done) nxt = abort ? IDLE : ((n_q == 32'd0) ? CHK : WAIT_BLK);
      WAIT_BLK: if (abort) nxt = IDLE;
                else if (blk_valid) nxt = PAY;
      PAY:      if (tx_done) nxt = abort ? IDLE :
                               (!last_byte ? PAY : (last_blk ? CHK : WAIT_BLK));
      CHK:      if (tx_done) nxt = DONE;   // completion beats a late abort
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      level_q  <= '0;
      n_q      <= '0;
      blk_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      chk      <= '0;
      launched <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      state   <= nxt;
      aborted <= (nxt == IDLE) && (state inside {HDR, LVL, WAIT_BLK, PAY});
      if (tx_start)     launched <= 1'b1;
      else if (tx_done) launched <= 1'b0;
      case (state)
        IDLE: if (start) begin
          level_q  <= Battery_level;
          n_q      <= all_group_num;
          blk_cnt  <= '0;
          byte_cnt <= '0;
          chk      <= '0;
        end
        LVL: if (tx_done) chk <= chk ^ {5'b0, level_q};
        WAIT_BLK: if (blk_valid) shreg <= blk_data;
        PAY: if (tx_done) begin
          chk   <= chk ^ shreg[7:0];
          shreg <= shreg >> 8;
          if (last_byte) begin
            byte_cnt <= '0;
            blk_cnt  <= blk_cnt + 32'd1;
          end else begin
            byte_cnt <= byte_cnt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  uart_byte_tx #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .tx_start (tx_start),
    .tx_byte  (tx_byte),
    .tx_done  (tx_done),
    .tx_busy  (tx_busy),
    .Rs232_Tx (Rs232_Tx)
  );

endmodule
